// File: rtl/alu_pkg.sv
// Shared ALU opcode codes, MIPS field constants, issue FSM states and the decoder.
// Pure combinational helpers; no state, no handshake.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_ADDU  = 4'b0010;
  localparam logic [3:0] OP_SUBU  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_ADDIU = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_ANDI  = 4'b1000;
  localparam logic [3:0] OP_ORI   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SLT   = 4'b1100;
  localparam logic [3:0] OP_SLTI  = 4'b1101;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_rtype;
    logic       is_shift;
    logic [3:0] op;
  } dec_t;

  function automatic dec_t decode_instr(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    if (opcode == OPC_RTYPE) begin
      d.is_rtype = 1'b1;
      case (funct)
        FN_ADD:  d.op = OP_ADD;
        FN_SUB:  d.op = OP_SUB;
        FN_ADDU: d.op = OP_ADDU;
        FN_SUBU: d.op = OP_SUBU;
        FN_AND:  d.op = OP_AND;
        FN_OR:   d.op = OP_OR;
        FN_SLT:  d.op = OP_SLT;
        FN_SLL:  begin d.op = OP_SLL; d.is_shift = 1'b1; end
        FN_SRL:  begin d.op = OP_SRL; d.is_shift = 1'b1; end
        default: d.legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        OPC_ADDI:  d.op = OP_ADDI;
        OPC_ADDIU: d.op = OP_ADDIU;
        OPC_ANDI:  d.op = OP_ANDI;
        OPC_ORI:   d.op = OP_ORI;
        OPC_SLTI:  d.op = OP_SLTI;
        default:   d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-in, operand-out and writeback bundle between the issue stage and its neighbours.
// master = environment side, slave = issue stage.
interface alu_issue_stage_if #(parameter int DATA_W = 32);
  logic              Instr_Valid;
  logic [31:0]       Instr_In;
  logic              Instr_Ready;
  logic              Issue_Valid;
  logic              Issue_Ready;
  logic [DATA_W-1:0] Data1;
  logic [DATA_W-1:0] Data2;
  logic [31:0]       Instruction;
  logic [3:0]        Opcode_ALU;
  logic [4:0]        Dest_Reg;
  logic              WB_En;
  logic [4:0]        WB_Reg;
  logic [DATA_W-1:0] WB_Data;
  logic              Illegal_Instr;

  modport master (
    output Instr_Valid, Instr_In, Issue_Ready, WB_En, WB_Reg, WB_Data,
    input  Instr_Ready, Issue_Valid, Data1, Data2, Instruction, Opcode_ALU, Dest_Reg, Illegal_Instr
  );

  modport slave (
    input  Instr_Valid, Instr_In, Issue_Ready, WB_En, WB_Reg, WB_Data,
    output Instr_Ready, Issue_Valid, Data1, Data2, Instruction, Opcode_ALU, Dest_Reg, Illegal_Instr
  );
endinterface

// File: rtl/issue_regfile.sv
// Register file: two async read ports with same-cycle write bypass, one write port, r0 reads zero.
// Reads are combinational; writes land on the rising edge, no backpressure.
module issue_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is never written, so the array read already yields zero for it
  assign rdata1_o = (wr_en && waddr_i == raddr1_i) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (wr_en && waddr_i == raddr2_i) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-read stage feeding the ALU, with busy-bit RAW scoreboard and writeback port.
// Issue_Valid two edges after acceptance when hazard-free; outputs frozen while Issue_Ready=0.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   bus
);

  state_e              state_q;
  logic [31:0]         instr_q;
  logic [31:0]         instr_out_q;
  logic [DATA_W-1:0]   data1_q, data2_q;
  logic [3:0]          op_q;
  logic [4:0]          dest_q;
  logic                issue_vld_q;
  logic                illegal_q;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  dec_t                dec;
  logic [4:0]          rs, rt, rd, raddr1, dest;
  logic [DATA_W-1:0]   rdata1, rdata2, operand2;
  logic [NUM_REGS-1:0] wb_mask, busy_eff;
  logic                hazard, issue_fire;

  assign dec    = decode_instr(instr_q[31:26], instr_q[5:0]);
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign raddr1 = dec.is_shift ? rt : rs;
  assign dest   = dec.is_rtype ? rd : rt;

  issue_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (bus.WB_En),
    .waddr_i  (bus.WB_Reg),
    .wdata_i  (bus.WB_Data),
    .raddr1_i (raddr1),
    .rdata1_o (rdata1),
    .raddr2_i (rt),
    .rdata2_o (rdata2)
  );

  // A register being written back this cycle is already safe to read through the bypass
  assign wb_mask  = (bus.WB_En && bus.WB_Reg != '0) ? (NUM_REGS'(1) << bus.WB_Reg) : '0;
  assign busy_eff = busy_q & ~wb_mask;

  always_comb begin
    hazard = busy_eff[rs];
    if (dec.is_rtype) hazard = dec.is_shift ? busy_eff[rt] : (busy_eff[rs] | busy_eff[rt]);
  end

  always_comb begin
    operand2 = DATA_W'(instr_q[15:0]);
    if (dec.is_rtype) operand2 = dec.is_shift ? DATA_W'(instr_q[10:6]) : rdata2;
  end

  assign issue_fire = issue_vld_q && bus.Issue_Ready;

  // Issue-side set is applied after the writeback clear so it wins on a collision
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (issue_fire && dest_q != '0) busy_d[dest_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      instr_out_q <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      op_q        <= '0;
      dest_q      <= '0;
      issue_vld_q <= 1'b0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Instr_Valid) begin
            instr_q <= bus.Instr_In;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          if (!dec.legal) begin
            illegal_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!hazard) begin
            data1_q     <= rdata1;
            data2_q     <= operand2;
            op_q        <= dec.op;
            dest_q      <= dest;
            instr_out_q <= instr_q;
            issue_vld_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.Issue_Ready) begin
            issue_vld_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Instr_Ready   = (state_q == IDLE) && !rst;
  assign bus.Issue_Valid   = issue_vld_q;
  assign bus.Data1         = data1_q;
  assign bus.Data2         = data2_q;
  assign bus.Instruction   = instr_out_q;
  assign bus.Opcode_ALU    = op_q;
  assign bus.Dest_Reg      = dest_q;
  assign bus.Illegal_Instr = illegal_q;

endmodule
